// File: rtl/dis_pal_pkg.sv
// dis_pal_pkg: shared types and constants for the PAL display timing block.
//   state_e      - top-level run state (StIdle, StRun)
//   PAL_*        - default progressive-field timing (864 x 312, 720 x 288 active)
//   BAR_COLOURS  - 8 vertical colour bars, 8 bits per channel (R, G, B), used
//                  only when DIS_PAL_TEST_PATTERN_EN is defined
package dis_pal_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned PAL_DATA_W   = 24;
    localparam int unsigned PAL_H_TOTAL  = 864;
    localparam int unsigned PAL_H_SYNC   = 64;
    localparam int unsigned PAL_H_START  = 132;
    localparam int unsigned PAL_H_ACTIVE = 720;
    localparam int unsigned PAL_V_TOTAL  = 312;
    localparam int unsigned PAL_V_SYNC   = 3;
    localparam int unsigned PAL_V_START  = 23;
    localparam int unsigned PAL_V_ACTIVE = 288;

    localparam int unsigned NUM_BARS = 8;

    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_COLOURS [NUM_BARS] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/dis_pal_hv_cnt.sv
// dis_pal_hv_cnt: horizontal/vertical counters and region decode.
//   clk, rst   - clock, synchronous active-high reset
//   run        - counters advance while high, held at 0 while low
//   hs_win     - h_cnt < H_SYNC
//   vs_win     - v_cnt < V_SYNC
//   line_act   - v_cnt inside the active lines
//   pix_act    - line_act and h_cnt inside the active pixels
//   rdy_win    - line_act and h_cnt one position ahead of the active pixels
//   frame_end  - last h_cnt of the last line
//   bar_idx    - colour bar under the current pixel (DIS_PAL_TEST_PATTERN_EN only)
module dis_pal_hv_cnt
    import dis_pal_pkg::*;
#(
    parameter int unsigned H_TOTAL  = PAL_H_TOTAL,
    parameter int unsigned H_SYNC   = PAL_H_SYNC,
    parameter int unsigned H_START  = PAL_H_START,
    parameter int unsigned H_ACTIVE = PAL_H_ACTIVE,
    parameter int unsigned V_TOTAL  = PAL_V_TOTAL,
    parameter int unsigned V_SYNC   = PAL_V_SYNC,
    parameter int unsigned V_START  = PAL_V_START,
    parameter int unsigned V_ACTIVE = PAL_V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       hs_win,
    output logic       vs_win,
    output logic       line_act,
    output logic       pix_act,
    output logic       rdy_win,
    output logic       frame_end
`ifdef DIS_PAL_TEST_PATTERN_EN
    ,
    output logic [2:0] bar_idx
`endif
);

    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_FIRST = HW'(H_START);
    localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_START + H_ACTIVE - 1);
    localparam logic [HW-1:0] H_RDY_FIRST = HW'(H_START - 1);
    localparam logic [HW-1:0] H_RDY_LAST  = HW'(H_START + H_ACTIVE - 2);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_FIRST = VW'(V_START);
    localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_START + V_ACTIVE - 1);

    logic [HW-1:0] h_cnt_q;
    logic [VW-1:0] v_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_q <= '0;
            v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_q <= h_cnt_q + HW'(1);
        end
    end

    assign hs_win    = h_cnt_q < H_SYNC_END;
    assign vs_win    = v_cnt_q < V_SYNC_END;
    assign line_act  = (v_cnt_q >= V_ACT_FIRST) && (v_cnt_q <= V_ACT_LAST);
    assign pix_act   = line_act && (h_cnt_q >= H_ACT_FIRST) && (h_cnt_q <= H_ACT_LAST);
    // Upstream answers one cycle late, so the request window leads pix_act by one.
    assign rdy_win   = line_act && (h_cnt_q >= H_RDY_FIRST) && (h_cnt_q <= H_RDY_LAST);
    assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

`ifdef DIS_PAL_TEST_PATTERN_EN
    localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / NUM_BARS);

    logic [HW-1:0] h_off;
    logic [HW-1:0] bar_full;

    assign h_off    = h_cnt_q - H_ACT_FIRST;
    assign bar_full = h_off / BAR_W;
    // Leftover pixels when H_ACTIVE is not a multiple of 8 stay on the last bar.
    assign bar_idx  = (bar_full > HW'(NUM_BARS - 1)) ? 3'd7 : bar_full[2:0];
`endif

endmodule

// File: rtl/dis_pal_timing.sv
// dis_pal_timing: PAL progressive field timing generator and pixel sink.
// Pulls pixels from the read-FIFO stage (valid answers ready one cycle later)
// and drives registered sync, data-enable and pixel outputs.
//   clk, rst        - clock, synchronous active-high reset
//   en              - run request; a stop only takes effect at frame end
//   vst_data/valid  - pixel stream from the read-FIFO stage
//   vst_ready       - pixel request, one cycle ahead of each active pixel
//   hsync, vsync    - active-high syncs
//   de, pix         - data enable and pixel (FILL on blanking or underflow)
//   underflow       - sticky: an active pixel found no valid data
//   err_clr         - clears underflow and stray_cnt (a same-cycle event wins)
//   stray_cnt       - valids arriving outside active pixels, saturating at 255
//   running         - high in the run state
//   pattern_sel     - colour bars instead of stream data (DIS_PAL_TEST_PATTERN_EN only)
module dis_pal_timing
    import dis_pal_pkg::*;
#(
    parameter int unsigned       DATA_W   = PAL_DATA_W,
    parameter int unsigned       H_TOTAL  = PAL_H_TOTAL,
    parameter int unsigned       H_SYNC   = PAL_H_SYNC,
    parameter int unsigned       H_START  = PAL_H_START,
    parameter int unsigned       H_ACTIVE = PAL_H_ACTIVE,
    parameter int unsigned       V_TOTAL  = PAL_V_TOTAL,
    parameter int unsigned       V_SYNC   = PAL_V_SYNC,
    parameter int unsigned       V_START  = PAL_V_START,
    parameter int unsigned       V_ACTIVE = PAL_V_ACTIVE,
    parameter logic [DATA_W-1:0] FILL     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] vst_data,
    input  logic              vst_valid,
    output logic              vst_ready,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [DATA_W-1:0] pix,
    output logic              underflow,
    input  logic              err_clr,
    output logic [7:0]        stray_cnt,
    output logic              running
`ifdef DIS_PAL_TEST_PATTERN_EN
    ,
    input  logic              pattern_sel
`endif
);

    state_e            state_q;
    logic              run;
    logic              hs_win, vs_win, line_act, pix_act, rdy_win, frame_end;
    logic              pat_on;
    logic              pix_act_run, uf_set, stray_set;
    logic [DATA_W-1:0] pix_d;
    logic              underflow_d;
    logic [7:0]        stray_d;

`ifdef DIS_PAL_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    assign pat_on = pattern_sel;
`else
    assign pat_on = 1'b0;
`endif

    assign run     = (state_q == StRun);
    assign running = run;

    dis_pal_hv_cnt #(
        .H_TOTAL  (H_TOTAL),
        .H_SYNC   (H_SYNC),
        .H_START  (H_START),
        .H_ACTIVE (H_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .V_SYNC   (V_SYNC),
        .V_START  (V_START),
        .V_ACTIVE (V_ACTIVE)
    ) u_hv_cnt (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .hs_win    (hs_win),
        .vs_win    (vs_win),
        .line_act  (line_act),
        .pix_act   (pix_act),
        .rdy_win   (rdy_win),
        .frame_end (frame_end)
`ifdef DIS_PAL_TEST_PATTERN_EN
        ,
        .bar_idx   (bar_idx)
`endif
    );

    // line_act is already folded into rdy_win.
    assign vst_ready = run && rdy_win && !pat_on;

    always_comb begin
        pix_act_run = run && pix_act;
        uf_set      = pix_act_run && !vst_valid && !pat_on;
        stray_set   = vst_valid && !pix_act_run;

        pix_d = FILL;
        if (pix_act_run && vst_valid) begin
            pix_d = vst_data;
        end
`ifdef DIS_PAL_TEST_PATTERN_EN
        if (pix_act_run && pat_on) begin
            pix_d = DATA_W'(BAR_COLOURS[bar_idx]);
        end
`endif

        // A new event overrides a coincident clear.
        underflow_d = underflow;
        if (uf_set) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end

        stray_d = stray_cnt;
        if (stray_set) begin
            if (err_clr) begin
                stray_d = 8'd1;
            end else if (stray_cnt != 8'hFF) begin
                stray_d = stray_cnt + 8'd1;
            end
        end else if (err_clr) begin
            stray_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            de        <= 1'b0;
            pix       <= '0;
            underflow <= 1'b0;
            stray_cnt <= 8'd0;
        end else begin
            case (state_q)
                StIdle: if (en) state_q <= StRun;
                // A mid-field stop request waits for the field to complete.
                StRun:  if (frame_end && !en) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            hsync     <= run && hs_win;
            vsync     <= run && vs_win;
            de        <= pix_act_run;
            pix       <= pix_d;
            underflow <= underflow_d;
            stray_cnt <= stray_d;
        end
    end

endmodule

// File: doc/dis_pal_timing.md
Name: dis_pal_timing

Overview:
- Downstream consumer of the PAL display read-FIFO stage.
- Generates PAL-style progressive field timing: H/V counters, hsync, vsync and data-enable.
- Pulls pixels from the read-FIFO stage with a ready/valid handshake and drives registered pixel/sync outputs to the DAC/encoder.
- The upstream stage asserts valid exactly one cycle after it samples ready, so this block raises ready one cycle ahead of each active pixel.

Parameters:
- DATA_W, 24, pixel width.
- H_TOTAL, 864, clocks per line.
- H_SYNC, 64, hsync width in clocks (h_cnt 0..H_SYNC-1).
- H_START, 132, first active h_cnt (must be ≥ 1).
- H_ACTIVE, 720, active pixels per line.
- V_TOTAL, 312, lines per field.
- V_SYNC, 3, vsync width in lines.
- V_START, 23, first active line.
- V_ACTIVE, 288, active lines.
- FILL, 0, pixel value driven on underflow or blanking.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  run request.
- vst_data  in  DATA_W  pixel from the read-FIFO stage.
- vst_valid  in  1  pixel valid; arrives one cycle after the ready it answers.
- vst_ready  out  1  pixel request.
- hsync  out  1  active-high.
- vsync  out  1  active-high.
- de  out  1  active video.
- pix  out  DATA_W  pixel out.
- underflow  out  1  sticky underflow flag.
- err_clr  in  1  clears underflow and stray_cnt.
- stray_cnt  out  8  count of unexpected valids, saturating at 255.
- running  out  1  high in RUN state.

Behaviour:
- Reset: all outputs 0, state IDLE, h_cnt = v_cnt = 0.
- States:
  - IDLE: counters held at 0; vst_ready, de, hsync, vsync = 0. Goes to RUN on the cycle after en is sampled high.
  - RUN: h_cnt runs 0..H_TOTAL-1 and wraps to 0, incrementing v_cnt. v_cnt wraps 0 after V_TOTAL-1.
  - RUN -> IDLE: only at the frame end (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1) with en = 0. A mid-field en drop completes the field first.
- Region definitions:
  - line_act = v_cnt in [V_START, V_START+V_ACTIVE-1].
  - pix_act = line_act and h_cnt in [H_START, H_START+H_ACTIVE-1].
- Ready: vst_ready is combinational from counters, high when RUN, line_act, and h_cnt in [H_START-1, H_START+H_ACTIVE-2]. This gives exactly H_ACTIVE ready cycles per active line, one cycle ahead of pix_act.
- Output registers: one-cycle latency from counters. At each edge in RUN:
  - hsync <= h_cnt < H_SYNC.
  - vsync <= v_cnt < V_SYNC.
  - de <= pix_act.
  - pix <= (pix_act and vst_valid) ? vst_data : FILL.
- Underflow: pix_act with vst_valid = 0 outputs FILL and sets underflow. Timing is never stretched to wait for data.
- Stray valid: vst_valid with pix_act = 0 (including IDLE, and the cycle after reset or stop) discards the data and increments stray_cnt.
- err_clr: clears underflow and stray_cnt. If err_clr coincides with a new event, the event wins (flag or count = 1).
- Simultaneous en rise and frame end while in RUN: stays in RUN.
- Mid-operation reset: immediate return to IDLE with all outputs 0. The pending valid from the upstream stage on the following cycle counts as stray.

Optional Feature:
- Macro: DIS_PAL_TEST_PATTERN_EN.
- When defined:
  - Adds input pattern_sel (1 bit).
  - When pattern_sel = 1, pix during pix_act carries 8 vertical colour bars, each H_ACTIVE/8 wide (white, yellow, cyan, green, magenta, red, blue, black at full scale per 8-bit channel).
  - vst_ready is held 0 and underflow is not set.
- When undefined: no port and no logic.

Decomposition:
- Package dis_pal_pkg:
  - state enum (IDLE, RUN).
  - default timing constants.
  - colour-bar constant array.
- Sub-module dis_pal_hv_cnt: counters, wrap logic and region decode (line_act, pix_act, ready window).

Test Plan:
- Reset, then en = 1 with a model read-FIFO (valid = ready delayed 1) always non-empty -> first de at line 23, h 132 (+1 cycle). Per line: 720 de cycles, 720 ready cycles. Per field: 288 de lines. underflow = 0, stray_cnt = 0.
- Model FIFO empty for 5 cycles mid-line 100 -> those 5 pix = FILL, de stays high, underflow = 1. err_clr -> underflow = 0.
- en dropped at line 50 -> running stays 1 until the cycle after h 863 / v 311, then 0. No ready pulses after that.
- Reset asserted on an active pixel with ready high -> next cycle all outputs 0. Model's trailing valid -> stray_cnt = 1.
- Small parameters (H_TOTAL 16, H_START 1, H_ACTIVE 4, V_TOTAL 6) -> ready at h 0..3, de at h 1..4 registered. h and v wrap correct across 3 fields.
- With DIS_PAL_TEST_PATTERN_EN and pattern_sel = 1 -> pix at h offsets 0, 90, 180 … = the 8 bar colours. vst_ready constant 0.
